drink_multi: RTL and testbench
==============================

// Module: drink_multi
// PURPOSE
//  Parametrised vending-machine controller; successor of the fixed 3-product drink FSM.
//  Supports N products with per-product price and stock, multi-value coins, cancel/refund,
//  and change paid serially, one unit per cycle.
//  Sits between the coin acceptor/keypad front end and the dispenser/change hopper drivers.
//  One money unit = R$0,50.
// PARAMETERS
//  N_PROD      4                 number of products (op selects 0..N_PROD-1)
//  OP_W        2                 width of op; must satisfy 2**OP_W >= N_PROD
//  SALDO_W     5                 width of saldo/troco/prices; SALDO_MAX = 2**SALDO_W-1
//  PRECOS      {5'd3,5'd5,5'd6,5'd4}  packed prices in units; product i at bits [i*SALDO_W +: SALDO_W]
//  STOCK_W     4                 width of each stock counter
//  STOCK_INIT  2                 stock loaded into every product on reset
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          synchronous, active-high reset
//  moeda           in   1          coin strobe, one cycle per coin
//  moeda_val       in   2          coin value: 1=1u, 2=2u, 3=4u, 0=invalid
//  op              in   OP_W       product select, sampled with confirma
//  confirma        in   1          purchase request strobe
//  cancela         in   1          refund request strobe
//  entrega         out  N_PROD     one-hot dispense pulse, 1 cycle
//  troco           out  SALDO_W    change/refund total latched at sale or cancel
//  troco_pulso     out  1          one money unit paid out this cycle
//  sinal_devolve   out  1          1-cycle pulse: cancel accepted
//  saldo           out  SALDO_W    current credit
//  erro            out  1          1-cycle pulse: purchase refused
//  sem_estoque     out  1          1-cycle pulse alongside erro when the refusal is due to stock=0
//  moeda_rej       out  1          1-cycle pulse: coin refused (invalid, overflow or busy)
//  ocupado         out  1          high while paying change
// BEHAVIOUR
//  Reset: state=IDLE; saldo=0; troco=0; all pulses/ocupado=0; every stock counter = STOCK_INIT.
//  States: IDLE, TROCO.
//  IDLE, priority cancela > confirma > moeda when asserted in the same cycle:
//   - cancela:
//       saldo>0: sinal_devolve=1 next cycle, troco<=saldo, go to TROCO.
//       saldo=0: ignored.
//   - confirma, refused when op>=N_PROD, stock[op]=0, or saldo<PRECO[op]:
//       erro=1 next cycle; sem_estoque=1 as well if stock[op]=0.
//       saldo unchanged; stay IDLE.
//   - confirma, accepted:
//       entrega[op]=1 exactly in cycle k+1 for confirma sampled at edge k.
//       stock[op]--; saldo<=saldo-PRECO[op]; troco<=remainder.
//       Next state is TROCO if remainder>0, else IDLE.
//   - moeda:
//       val=0, or saldo+val>SALDO_MAX: moeda_rej=1, saldo unchanged.
//       otherwise saldo<=saldo+val next cycle.
//   - A coin arriving in the same cycle as an accepted confirma or cancela is refused (moeda_rej).
//  TROCO:
//   - ocupado=1; troco_pulso=1 every cycle.
//   - saldo decrements by 1 per cycle; return to IDLE when saldo reaches 0.
//     Exactly troco pulses are produced.
//   - confirma and cancela are ignored; moeda yields moeda_rej.
//   - troco holds its value until the next sale or cancel.
//  rst at any time, including mid-TROCO, aborts immediately to reset values; no further pulses.
//  Arithmetic: all in SALDO_W bits; overflow checked with a SALDO_W+1 sum. Stock never wraps below 0.
// STRUCTURE
//  drink_defs.vh: state encodings, moeda_val decode constants (unit values 1/2/4).
//  Sub-module troco_serial: loadable down-counter producing troco_pulso/ocupado.
//  Stock counters: generate loop in top.
// TESTING
//  1 4x moeda(val=1), op=0, confirma -> entrega=0001 one cycle; saldo=0; no troco_pulso.
//  2 3x moeda(val=1), op=2, confirma -> erro=1, saldo=3.
//    Then cancela -> sinal_devolve=1, troco=3, 3 troco_pulso cycles, saldo=0.
//  3 moeda(val=3)+3x moeda(val=1) (saldo=7), op=1, confirma -> entrega=0010, troco=1, 1 troco_pulso.
//  4 Buy op=3 twice (3u each) -> both delivered.
//    Third attempt with saldo=3 -> erro=1, sem_estoque=1, saldo stays 3.
//  5 7x val=3 -> saldo=28; val=3 -> moeda_rej, saldo=28; val=2 -> saldo=30; val=0 -> moeda_rej.
//  6 cancela+confirma same cycle with saldo=6 -> cancel wins, no entrega.
//    rst during 2nd troco_pulso -> all outputs 0 next cycle, stocks=2.

Source files
------------

// File: rtl/drink_multi_pkg.sv
// Shared types and coin decoding for the multi-product drink vending controller.
// One money unit is R$0,50; coin codes map to 1, 2 or 4 units, code 0 is invalid.
package drink_multi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TROCO = 1'b1
  } state_t;

  localparam logic [1:0] COIN_INVALID = 2'd0;
  localparam logic [1:0] COIN_1U      = 2'd1;
  localparam logic [1:0] COIN_2U      = 2'd2;
  localparam logic [1:0] COIN_4U      = 2'd3;
  localparam int         COIN_UNIT_W  = 3;

  function automatic logic [COIN_UNIT_W-1:0] coin_units(input logic [1:0] val);
    case (val)
      COIN_1U: return 3'd1;
      COIN_2U: return 3'd2;
      COIN_4U: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/drink_multi_troco_serial.sv
// Loadable down-counter that pays change one money unit per cycle.
// While the count is non-zero the hopper receives a pulse each cycle.
module drink_multi_troco_serial #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count,
  output logic         o_pulso,
  output logic         o_busy
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (r_count != '0)
      r_count <= r_count - W'(1);
  end

  assign o_count = r_count;
  assign o_pulso = (r_count != '0);
  assign o_busy  = (r_count != '0);

endmodule

// File: rtl/drink_multi.sv
// Vending controller: N products with price/stock, multi-value coins, cancel/refund,
// and serial change payout through the troco_serial down-counter.
module drink_multi
  import drink_multi_pkg::*;
#(
  parameter int                        N_PROD     = 4,
  parameter int                        OP_W       = 2,
  parameter int                        SALDO_W    = 5,
  parameter logic [N_PROD*SALDO_W-1:0] PRECOS     = {5'd3, 5'd5, 5'd6, 5'd4},
  parameter int                        STOCK_W    = 4,
  parameter int                        STOCK_INIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               moeda,
  input  logic [1:0]         moeda_val,
  input  logic [OP_W-1:0]    op,
  input  logic               confirma,
  input  logic               cancela,
  output logic [N_PROD-1:0]  entrega,
  output logic [SALDO_W-1:0] troco,
  output logic               troco_pulso,
  output logic               sinal_devolve,
  output logic [SALDO_W-1:0] saldo,
  output logic               erro,
  output logic               sem_estoque,
  output logic               moeda_rej,
  output logic               ocupado
);

  localparam int OP_N = 2 ** OP_W;

  state_t r_state, w_next_state;

  logic [SALDO_W-1:0] r_saldo, r_troco;
  logic [N_PROD-1:0]  r_entrega;
  logic               r_devolve, r_erro, r_sem, r_rej;

  logic [STOCK_W-1:0] w_stock_ext [OP_N];
  logic [SALDO_W-1:0] w_price_ext [OP_N];
  logic [OP_N-1:0]    w_op_valid;

  logic               w_do_cancel, w_do_sale, w_do_refuse, w_do_coin, w_coin_rej;
  logic [SALDO_W-1:0] w_count;
  logic               w_pulso, w_busy;

  // Select codes beyond N_PROD read as invalid, out-of-stock, zero-price slots.
  generate
    for (genvar gi = 0; gi < OP_N; gi++) begin : g_prod
      if (gi < N_PROD) begin : g_real
        logic [STOCK_W-1:0] r_stock;
        always_ff @(posedge clk) begin
          if (rst)
            r_stock <= STOCK_W'(STOCK_INIT);
          else if (w_do_sale && op == OP_W'(gi))
            r_stock <= r_stock - STOCK_W'(1);
        end
        assign w_stock_ext[gi] = r_stock;
        assign w_price_ext[gi] = PRECOS[gi*SALDO_W +: SALDO_W];
        assign w_op_valid[gi]  = 1'b1;
      end else begin : g_pad
        assign w_stock_ext[gi] = '0;
        assign w_price_ext[gi] = '0;
        assign w_op_valid[gi]  = 1'b0;
      end
    end
  endgenerate

  logic               w_sel_valid, w_stock_empty, w_buy_ok, w_coin_ok;
  logic [SALDO_W-1:0] w_sel_price, w_rem;
  logic [SALDO_W:0]   w_coin_sum;

  assign w_sel_valid   = w_op_valid[op];
  assign w_sel_price   = w_price_ext[op];
  assign w_stock_empty = w_sel_valid && (w_stock_ext[op] == '0);
  assign w_buy_ok      = w_sel_valid && !w_stock_empty && (r_saldo >= w_sel_price);
  assign w_rem         = r_saldo - w_sel_price;
  assign w_coin_sum    = {1'b0, r_saldo} + (SALDO_W+1)'(coin_units(moeda_val));
  assign w_coin_ok     = (moeda_val != COIN_INVALID) && !w_coin_sum[SALDO_W];

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // A cancel with zero credit falls through, so confirma/moeda are still evaluated.
  always_comb begin
    w_next_state = r_state;
    w_do_cancel  = 1'b0;
    w_do_sale    = 1'b0;
    w_do_refuse  = 1'b0;
    w_do_coin    = 1'b0;
    w_coin_rej   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cancela && r_saldo != '0) begin
          w_do_cancel  = 1'b1;
          w_coin_rej   = moeda;
          w_next_state = ST_TROCO;
        end else if (confirma && w_buy_ok) begin
          w_do_sale  = 1'b1;
          w_coin_rej = moeda;
          if (w_rem != '0)
            w_next_state = ST_TROCO;
        end else begin
          w_do_refuse = confirma;
          if (moeda) begin
            w_do_coin  = w_coin_ok;
            w_coin_rej = !w_coin_ok;
          end
        end
      end
      ST_TROCO: begin
        w_coin_rej = moeda;
        if (w_count <= SALDO_W'(1))
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Credit moves into the change counter on a sale or cancel, so r_saldo drops to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_saldo   <= '0;
      r_troco   <= '0;
      r_entrega <= '0;
      r_devolve <= 1'b0;
      r_erro    <= 1'b0;
      r_sem     <= 1'b0;
      r_rej     <= 1'b0;
    end else begin
      r_entrega <= w_do_sale ? (N_PROD'(1) << op) : '0;
      r_devolve <= w_do_cancel;
      r_erro    <= w_do_refuse;
      r_sem     <= w_do_refuse && w_stock_empty;
      r_rej     <= w_coin_rej;
      if (w_do_cancel) begin
        r_troco <= r_saldo;
        r_saldo <= '0;
      end else if (w_do_sale) begin
        r_troco <= w_rem;
        r_saldo <= '0;
      end else if (w_do_coin) begin
        r_saldo <= w_coin_sum[SALDO_W-1:0];
      end
    end
  end

  drink_multi_troco_serial #(.W(SALDO_W)) u_troco (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_do_cancel || w_do_sale),
    .i_value (w_do_cancel ? r_saldo : w_rem),
    .o_count (w_count),
    .o_pulso (w_pulso),
    .o_busy  (w_busy)
  );

  assign entrega       = r_entrega;
  assign troco         = r_troco;
  assign troco_pulso   = w_pulso;
  assign sinal_devolve = r_devolve;
  assign saldo         = (r_state == ST_TROCO) ? w_count : r_saldo;
  assign erro          = r_erro;
  assign sem_estoque   = r_sem;
  assign moeda_rej     = r_rej;
  assign ocupado       = w_busy;

endmodule

// File: tb/tb_drink_multi.sv
// Self-checking bench for drink_multi: coin/purchase vector table, directed corner
// sequences and randomized traffic against a rule-level vending model.
module tb_drink_multi;

  logic       clk = 1'b0;
  logic       rst, moeda, confirma, cancela;
  logic [1:0] moeda_val, op;
  logic [3:0] entrega;
  logic [4:0] troco, saldo;
  logic       troco_pulso, sinal_devolve, erro, sem_estoque, moeda_rej, ocupado;

  int errors = 0;
  int checks = 0;

  drink_multi dut (
    .clk(clk), .rst(rst), .moeda(moeda), .moeda_val(moeda_val), .op(op),
    .confirma(confirma), .cancela(cancela), .entrega(entrega), .troco(troco),
    .troco_pulso(troco_pulso), .sinal_devolve(sinal_devolve), .saldo(saldo),
    .erro(erro), .sem_estoque(sem_estoque), .moeda_rej(moeda_rej), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Reference model: credit, stock and change still owed, as plain integers.
  int         mSaldo, mLeft, mTroco;
  int         mStock [4];
  int         mPrice [4] = '{4, 6, 5, 3};
  logic [3:0] eEntrega;
  logic       eDevolve, eErro, eSem, eRej;

  task automatic modelStep(input logic r, m, input logic [1:0] v, o, input logic cf, cc);
    int units;
    eEntrega = '0; eDevolve = 0; eErro = 0; eSem = 0; eRej = 0;
    if (r) begin
      mSaldo = 0; mLeft = 0; mTroco = 0;
      foreach (mStock[i]) mStock[i] = 2;
    end else if (mLeft > 0) begin
      mLeft--;
      eRej = m;
    end else if (cc && mSaldo > 0) begin
      eDevolve = 1; mTroco = mSaldo; mLeft = mSaldo; mSaldo = 0; eRej = m;
    end else if (cf && mStock[o] > 0 && mSaldo >= mPrice[o]) begin
      eEntrega = 4'(1) << o;
      mStock[o]--;
      mTroco = mSaldo - mPrice[o]; mLeft = mTroco; mSaldo = 0; eRej = m;
    end else begin
      if (cf) begin
        eErro = 1;
        eSem  = (mStock[o] == 0);
      end
      if (m) begin
        units = (v == 2'd1) ? 1 : (v == 2'd2) ? 2 : (v == 2'd3) ? 4 : 0;
        if (units == 0 || mSaldo + units > 31) eRej = 1;
        else mSaldo += units;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, m, input logic [1:0] v, o, input logic cf, cc);
    rst = r; moeda = m; moeda_val = v; op = o; confirma = cf; cancela = cc;
    modelStep(r, m, v, o, cf, cc);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkModel(input int cyc);
    string t;
    t = $sformatf("rand%0d", cyc);
    checkOutput({t, ".entrega"}, 32'(entrega), 32'(eEntrega));
    checkOutput({t, ".troco"}, 32'(troco), 32'(mTroco));
    checkOutput({t, ".troco_pulso"}, 32'(troco_pulso), 32'(mLeft > 0));
    checkOutput({t, ".devolve"}, 32'(sinal_devolve), 32'(eDevolve));
    checkOutput({t, ".saldo"}, 32'(saldo), (mLeft > 0) ? 32'(mLeft) : 32'(mSaldo));
    checkOutput({t, ".erro"}, 32'(erro), 32'(eErro));
    checkOutput({t, ".sem_estoque"}, 32'(sem_estoque), 32'(eSem));
    checkOutput({t, ".moeda_rej"}, 32'(moeda_rej), 32'(eRej));
    checkOutput({t, ".ocupado"}, 32'(ocupado), 32'(mLeft > 0));
  endtask

  task automatic checkAllZero(input string t);
    checkOutput({t, ".entrega"}, 32'(entrega), 0);
    checkOutput({t, ".troco"}, 32'(troco), 0);
    checkOutput({t, ".troco_pulso"}, 32'(troco_pulso), 0);
    checkOutput({t, ".devolve"}, 32'(sinal_devolve), 0);
    checkOutput({t, ".saldo"}, 32'(saldo), 0);
    checkOutput({t, ".erro"}, 32'(erro), 0);
    checkOutput({t, ".sem_estoque"}, 32'(sem_estoque), 0);
    checkOutput({t, ".moeda_rej"}, 32'(moeda_rej), 0);
    checkOutput({t, ".ocupado"}, 32'(ocupado), 0);
  endtask

  // Counts change pulses from the current sample on, bounded by a cycle budget.
  task automatic drainChange(input string t, output int n);
    n = 0;
    while (troco_pulso === 1'b1 && n < 64) begin
      n++;
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    if (n >= 64) checkOutput({t, ".drain_timeout"}, 32'(n), 0);
  endtask

  task automatic coins1(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 1, 2'd1, 0, 0, 0);
  endtask

  typedef struct {
    logic       m;
    logic [1:0] v;
    logic [1:0] o;
    logic       cf;
    logic       cc;
    logic [3:0] eEnt;
    logic [4:0] eSaldo;
    logic       eErro;
    logic       eRej;
    logic       ePulso;
  } vec_t;

  vec_t vecs[$];

  task automatic pushVec(input logic m, input logic [1:0] v, o, input logic cf, cc,
                         input logic [3:0] ent, input logic [4:0] sal,
                         input logic er, rj, pu);
    vec_t tmp;
    tmp.m = m; tmp.v = v; tmp.o = o; tmp.cf = cf; tmp.cc = cc;
    tmp.eEnt = ent; tmp.eSaldo = sal; tmp.eErro = er; tmp.eRej = rj; tmp.ePulso = pu;
    vecs.push_back(tmp);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1; moeda = 0; moeda_val = 0; op = 0; confirma = 0; cancela = 0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'd3, 0, 1, 1);
    checkAllZero("reset");

    // Coin-and-buy table: exact price purchase, then coin overflow limits.
    for (int i = 1; i <= 4; i++) pushVec(1, 2'd1, 0, 0, 0, 4'b0000, 5'(i), 0, 0, 0);
    pushVec(0, 0, 2'd0, 1, 0, 4'b0001, 5'd0, 0, 0, 0);
    pushVec(0, 0, 0, 0, 0, 4'b0000, 5'd0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) pushVec(1, 2'd3, 0, 0, 0, 4'b0000, 5'(4 * i), 0, 0, 0);
    pushVec(1, 2'd3, 0, 0, 0, 4'b0000, 5'd28, 0, 1, 0);
    pushVec(1, 2'd2, 0, 0, 0, 4'b0000, 5'd30, 0, 0, 0);
    pushVec(1, 2'd0, 0, 0, 0, 4'b0000, 5'd30, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].m, vecs[i].v, vecs[i].o, vecs[i].cf, vecs[i].cc);
      checkOutput($sformatf("vec%0d.entrega", i), 32'(entrega), 32'(vecs[i].eEnt));
      checkOutput($sformatf("vec%0d.saldo", i), 32'(saldo), 32'(vecs[i].eSaldo));
      checkOutput($sformatf("vec%0d.erro", i), 32'(erro), 32'(vecs[i].eErro));
      checkOutput($sformatf("vec%0d.moeda_rej", i), 32'(moeda_rej), 32'(vecs[i].eRej));
      checkOutput($sformatf("vec%0d.troco_pulso", i), 32'(troco_pulso), 32'(vecs[i].ePulso));
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("full_refund.devolve", 32'(sinal_devolve), 1);
    checkOutput("full_refund.troco", 32'(troco), 30);
    drainChange("full_refund", n);
    checkOutput("full_refund.pulses", 32'(n), 30);
    checkOutput("full_refund.saldo", 32'(saldo), 0);
    checkOutput("full_refund.troco_hold", 32'(troco), 30);

    // Refused purchase (insufficient credit), then cancel with a coin during payout.
    applyStimulus(1, 0, 0, 0, 0, 0);
    coins1(3);
    applyStimulus(0, 0, 0, 2'd2, 1, 0);
    checkOutput("short.erro", 32'(erro), 1);
    checkOutput("short.sem_estoque", 32'(sem_estoque), 0);
    checkOutput("short.entrega", 32'(entrega), 0);
    checkOutput("short.saldo", 32'(saldo), 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("cancel.devolve", 32'(sinal_devolve), 1);
    checkOutput("cancel.troco", 32'(troco), 3);
    checkOutput("cancel.ocupado", 32'(ocupado), 1);
    applyStimulus(0, 1, 2'd1, 0, 0, 0);
    checkOutput("cancel.busy_rej", 32'(moeda_rej), 1);
    checkOutput("cancel.saldo_mid", 32'(saldo), 2);
    drainChange("cancel", n);
    checkOutput("cancel.pulses", 32'(n + 1), 3);
    checkOutput("cancel.saldo_end", 32'(saldo), 0);

    // Sale with one unit of change.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2'd3, 0, 0, 0);
    coins1(3);
    applyStimulus(0, 0, 0, 2'd1, 1, 0);
    checkOutput("change.entrega", 32'(entrega), 4'b0010);
    checkOutput("change.troco", 32'(troco), 1);
    drainChange("change", n);
    checkOutput("change.pulses", 32'(n), 1);
    checkOutput("change.entrega_off", 32'(entrega), 0);

    // Stock exhaustion on product 3; the second buy also carries a refused coin.
    applyStimulus(1, 0, 0, 0, 0, 0);
    coins1(3);
    applyStimulus(0, 0, 0, 2'd3, 1, 0);
    checkOutput("stock.buy1", 32'(entrega), 4'b1000);
    coins1(3);
    applyStimulus(0, 1, 2'd1, 2'd3, 1, 0);
    checkOutput("stock.buy2", 32'(entrega), 4'b1000);
    checkOutput("stock.buy2_coin_rej", 32'(moeda_rej), 1);
    checkOutput("stock.buy2_saldo", 32'(saldo), 0);
    coins1(3);
    applyStimulus(0, 0, 0, 2'd3, 1, 0);
    checkOutput("stock.buy3_erro", 32'(erro), 1);
    checkOutput("stock.buy3_sem", 32'(sem_estoque), 1);
    checkOutput("stock.buy3_entrega", 32'(entrega), 0);
    checkOutput("stock.buy3_saldo", 32'(saldo), 3);

    // Cancel beats confirma; reset mid-payout clears outputs and reloads stock.
    applyStimulus(0, 1, 2'd1, 0, 0, 0);
    applyStimulus(0, 1, 2'd2, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'd0, 1, 1);
    checkOutput("prio.devolve", 32'(sinal_devolve), 1);
    checkOutput("prio.entrega", 32'(entrega), 0);
    checkOutput("prio.erro", 32'(erro), 0);
    checkOutput("prio.troco", 32'(troco), 6);
    checkOutput("prio.pulso", 32'(troco_pulso), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkAllZero("midreset");
    coins1(3);
    applyStimulus(0, 0, 0, 2'd3, 1, 0);
    checkOutput("midreset.restock", 32'(entrega), 4'b1000);

    // Randomized traffic against the model.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 2, $urandom_range(0, 24) == 0);
      checkModel(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
